// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Purpose:
//   Instruction fetch front end. Issues one instruction-memory request per
//   accepted PC, keeps the PCs of in-flight requests in order, pairs each
//   in-order memory response with its PC and queues {pc, instr} in a small
//   fetch buffer that the decode stage drains with a valid/ready handshake.
//   A redirect (i_flush) empties the buffer and turns every in-flight
//   request into a "discard" credit so that its late response is dropped.
//
// Parameters:
//   BUF_DEPTH        fetch buffer entries and max in-flight requests
//                    (power of two, >= 2)
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset
//   i_pc             fetch address from the program counter
//   o_pc_stall       high when i_pc was not consumed this cycle
//   o_imem_req       instruction-memory request
//   o_imem_addr      request address (i_pc, combinational)
//   i_imem_gnt       memory grant for the current request
//   i_imem_rvalid    in-order response valid
//   i_imem_rdata     response data (instruction word)
//   o_id_valid       head buffer entry is available to decode
//   o_id_instr       head entry instruction
//   o_id_pc          head entry PC
//   i_id_ready       decode accepts the head entry
//   i_flush          redirect: discard buffered and in-flight fetches
//   o_id_misaligned  head entry is a misaligned-fetch fault
//
// Configuration:
//   IFETCH_ALIGN_CHECK_EN  when defined, a PC with non-zero bits [1:0] is not
//                          sent to memory; once no real request is in flight
//                          a fault entry {pc, instr=0, misaligned=1} is
//                          queued instead. When undefined the PC is passed
//                          through untouched and o_id_misaligned is 0.
// ----------------------------------------------------------------------------
module instr_fetch #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  output logic        o_pc_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_id_valid,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pc,
  input  logic        i_id_ready,
  input  logic        i_flush,
  output logic        o_id_misaligned
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W = CNT_W + 2;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;

  cnt_t outstanding_q, outstanding_d;
  cnt_t discard_q,     discard_d;
  cnt_t bufCount_q,    bufCount_d;
  ptr_t bufHead_q,     bufHead_d;
  ptr_t bufTail_q,     bufTail_d;
  ptr_t ifHead_q,      ifHead_d;
  ptr_t ifTail_q,      ifTail_d;

  logic [31:0] ifPc_q     [BUF_DEPTH];
  logic [31:0] bufPc_q    [BUF_DEPTH];
  logic [31:0] bufInstr_q [BUF_DEPTH];
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        bufMis_q   [BUF_DEPTH];
`endif

  logic [SUM_W-1:0] inUse;
  logic             credit;
  logic             pcMisaligned;
  logic             accepted;
  logic             misPush;
  logic             rspPending;
  logic             rspTake;
  logic             bufPush;
  logic             bufPop;
  logic             bufNotEmpty;
  logic [31:0]      pushPc;
  logic [31:0]      pushInstr;

  // Credit counts everything that will eventually occupy a buffer slot:
  // live requests, requests whose responses must still be dropped, and
  // entries already queued. A pop in the same cycle returns no credit.
  assign inUse  = SUM_W'(outstanding_q) + SUM_W'(discard_q) + SUM_W'(bufCount_q);
  assign credit = (inUse < SUM_W'(BUF_DEPTH));

`ifdef IFETCH_ALIGN_CHECK_EN
  assign pcMisaligned = |i_pc[1:0];
`else
  assign pcMisaligned = 1'b0;
`endif

  // A misaligned PC never reaches memory. Its fault entry is queued only
  // when no real request is in flight so it lands behind older responses.
  assign o_imem_req  = credit & ~i_flush & ~i_rst & ~pcMisaligned;
  assign o_imem_addr = i_pc;
  assign accepted    = o_imem_req & i_imem_gnt;
  assign misPush     = pcMisaligned & (outstanding_q == '0) & credit & ~i_flush & ~i_rst;
  assign o_pc_stall  = ~(accepted | misPush);

  // A response beat only means something while some request is owed one.
  // Discards are older than live requests, so they are retired first.
  assign rspPending = i_imem_rvalid & ((discard_q != '0) | (outstanding_q != '0));
  assign rspTake    = i_imem_rvalid & ~i_flush & (discard_q == '0) & (outstanding_q != '0);

  assign bufPush   = rspTake | misPush;
  assign pushPc    = rspTake ? ifPc_q[ifHead_q] : i_pc;
  assign pushInstr = rspTake ? i_imem_rdata : 32'h0;

  assign bufNotEmpty = (bufCount_q != '0);
  assign o_id_valid  = bufNotEmpty & ~i_flush;
  assign bufPop      = o_id_valid & i_id_ready;

  // The head entry is forced to zero while the buffer is empty so the
  // decode-side outputs read 0 after reset regardless of stale storage.
  assign o_id_pc    = bufNotEmpty ? bufPc_q[bufHead_q]    : 32'h0;
  assign o_id_instr = bufNotEmpty ? bufInstr_q[bufHead_q] : 32'h0;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign o_id_misaligned = bufNotEmpty & bufMis_q[bufHead_q];
`else
  assign o_id_misaligned = 1'b0;
`endif

  // Next-state for counters and pointers. A flush collapses the buffer and
  // the in-flight PC queue, and converts every owed response (minus a beat
  // arriving in the flush cycle itself) into a discard.
  always_comb begin
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    bufCount_d    = bufCount_q;
    bufHead_d     = bufHead_q;
    bufTail_d     = bufTail_q;
    ifHead_d      = ifHead_q;
    ifTail_d      = ifTail_q;

    if (i_flush) begin
      discard_d     = discard_q + outstanding_q - cnt_t'(rspPending);
      outstanding_d = '0;
      bufCount_d    = '0;
      bufHead_d     = '0;
      bufTail_d     = '0;
      ifHead_d      = '0;
      ifTail_d      = '0;
    end else begin
      if (i_imem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - cnt_t'(1);
      end
      outstanding_d = outstanding_q + cnt_t'(accepted) - cnt_t'(rspTake);
      bufCount_d    = bufCount_q + cnt_t'(bufPush) - cnt_t'(bufPop);
      if (bufPush) begin
        bufTail_d = bufTail_q + ptr_t'(1);
      end
      if (bufPop) begin
        bufHead_d = bufHead_q + ptr_t'(1);
      end
      if (accepted) begin
        ifTail_d = ifTail_q + ptr_t'(1);
      end
      if (rspTake) begin
        ifHead_d = ifHead_q + ptr_t'(1);
      end
    end
  end

  // Control state with synchronous reset. Clearing the outstanding and
  // discard counts makes any response to a pre-reset request look like a
  // stray beat, which is then ignored.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      outstanding_q <= '0;
      discard_q     <= '0;
      bufCount_q    <= '0;
      bufHead_q     <= '0;
      bufTail_q     <= '0;
      ifHead_q      <= '0;
      ifTail_q      <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      bufCount_q    <= bufCount_d;
      bufHead_q     <= bufHead_d;
      bufTail_q     <= bufTail_d;
      ifHead_q      <= ifHead_d;
      ifTail_q      <= ifTail_d;
    end
  end

  // Data storage needs no reset: every read is qualified by the counts.
  always_ff @(posedge i_clk) begin
    if (accepted) begin
      ifPc_q[ifTail_q] <= i_pc;
    end
    if (bufPush) begin
      bufPc_q[bufTail_q]    <= pushPc;
      bufInstr_q[bufTail_q] <= pushInstr;
`ifdef IFETCH_ALIGN_CHECK_EN
      bufMis_q[bufTail_q]   <= misPush;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch with BUF_DEPTH = 2. Inputs are driven just
// after the falling edge and outputs are sampled 1 time unit later, well
// away from the rising edge. Expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pcStall;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        idValid;
  logic [31:0] idInstr;
  logic [31:0] idPc;
  logic        idReady;
  logic        flush;
  logic        idMisaligned;

  int checks = 0;
  int errors = 0;

  instr_fetch #(
    .BUF_DEPTH(2)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_pc            (pc),
    .o_pc_stall      (pcStall),
    .o_imem_req      (imemReq),
    .o_imem_addr     (imemAddr),
    .i_imem_gnt      (imemGnt),
    .i_imem_rvalid   (imemRvalid),
    .i_imem_rdata    (imemRdata),
    .o_id_valid      (idValid),
    .o_id_instr      (idInstr),
    .o_id_pc         (idPc),
    .i_id_ready      (idReady),
    .i_flush         (flush),
    .o_id_misaligned (idMisaligned)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs after the falling edge, then settle.
  task automatic applyStimulus(input logic        rstV,
                               input logic [31:0] pcV,
                               input logic        gntV,
                               input logic        rvalidV,
                               input logic [31:0] rdataV,
                               input logic        readyV,
                               input logic        flushV);
    @(negedge clk);
    rst        = rstV;
    pc         = pcV;
    imemGnt    = gntV;
    imemRvalid = rvalidV;
    imemRdata  = rdataV;
    idReady    = readyV;
    flush      = flushV;
    #1;
  endtask

  // One comparison: count it, and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Linear sequence of directed steps.
  initial begin
    rst = 1'b1; pc = '0; imemGnt = 0; imemRvalid = 0; imemRdata = '0;
    idReady = 0; flush = 0;

    // Reset behaviour and post-reset output state.
    applyStimulus(1, 32'h0, 0, 0, 32'h0, 0, 0);
    checkOutput("rst_req", imemReq, 0);
    checkOutput("rst_stall", pcStall, 1);
    applyStimulus(1, 32'h0, 1, 0, 32'h0, 0, 0);
    checkOutput("rst_req_gnt", imemReq, 0);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 0);
    checkOutput("post_rst_valid", idValid, 0);
    checkOutput("post_rst_instr", idInstr, 32'h0);
    checkOutput("post_rst_pc", idPc, 32'h0);
    checkOutput("post_rst_mis", idMisaligned, 0);

    // Single fetch: grant, rvalid next cycle, valid the cycle after.
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 1, 0);
    checkOutput("t1_req", imemReq, 1);
    checkOutput("t1_stall", pcStall, 0);
    checkOutput("t1_addr", imemAddr, 32'h0);
    applyStimulus(0, 32'h4, 0, 1, 32'h2002_0005, 1, 0);
    checkOutput("t1_valid_early", idValid, 0);
    checkOutput("t1_stall_nognt", pcStall, 1);
    applyStimulus(0, 32'h4, 0, 0, 32'h0, 1, 0);
    checkOutput("t1_valid", idValid, 1);
    checkOutput("t1_instr", idInstr, 32'h2002_0005);
    checkOutput("t1_pc", idPc, 32'h0);
    applyStimulus(0, 32'h4, 0, 0, 32'h0, 0, 0);
    checkOutput("t1_popped", idValid, 0);

    // Back-pressure: two grants fill the credit, req drops until a pop.
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 0, 0);
    checkOutput("t2_stall0", pcStall, 0);
    applyStimulus(0, 32'h4, 1, 0, 32'h0, 0, 0);
    checkOutput("t2_req1", imemReq, 1);
    checkOutput("t2_stall1", pcStall, 0);
    applyStimulus(0, 32'h8, 1, 1, 32'h0000_00A0, 0, 0);
    checkOutput("t2_req_full", imemReq, 0);
    checkOutput("t2_stall_full", pcStall, 1);
    applyStimulus(0, 32'h8, 1, 1, 32'h0000_00A4, 0, 0);
    checkOutput("t2_req_full2", imemReq, 0);
    checkOutput("t2_head_pc", idPc, 32'h0);
    checkOutput("t2_head_instr", idInstr, 32'h0000_00A0);
    applyStimulus(0, 32'h8, 1, 0, 32'h0, 0, 0);
    checkOutput("t2_hold_req", imemReq, 0);
    checkOutput("t2_hold_stall", pcStall, 1);
    checkOutput("t2_hold_valid", idValid, 1);
    checkOutput("t2_hold_pc", idPc, 32'h0);
    applyStimulus(0, 32'h8, 1, 0, 32'h0, 0, 0);
    checkOutput("t2_hold_pc2", idPc, 32'h0);
    checkOutput("t2_hold_instr2", idInstr, 32'h0000_00A0);
    applyStimulus(0, 32'h8, 0, 0, 32'h0, 1, 0);
    checkOutput("t2_pop_pc", idPc, 32'h0);
    checkOutput("t2_pop_cycle_req", imemReq, 0);
    applyStimulus(0, 32'h8, 0, 0, 32'h0, 1, 0);
    checkOutput("t2_second_pc", idPc, 32'h4);
    checkOutput("t2_second_instr", idInstr, 32'h0000_00A4);
    checkOutput("t2_req_back", imemReq, 1);
    applyStimulus(0, 32'h8, 0, 0, 32'h0, 0, 0);
    checkOutput("t2_empty", idValid, 0);

    // Flush with two requests in flight: both late beats are dropped.
    applyStimulus(0, 32'h10, 1, 0, 32'h0, 0, 0);
    applyStimulus(0, 32'h14, 1, 0, 32'h0, 0, 0);
    applyStimulus(0, 32'h18, 0, 0, 32'h0, 0, 1);
    checkOutput("t3_flush_req", imemReq, 0);
    checkOutput("t3_flush_valid", idValid, 0);
    applyStimulus(0, 32'h18, 0, 1, 32'h0000_BAD0, 0, 0);
    checkOutput("t3_discard2_req", imemReq, 0);
    applyStimulus(0, 32'h18, 0, 1, 32'h0000_BAD4, 0, 0);
    checkOutput("t3_drop1_valid", idValid, 0);
    applyStimulus(0, 32'h18, 0, 0, 32'h0, 0, 0);
    checkOutput("t3_drop2_valid", idValid, 0);
    checkOutput("t3_req_resume", imemReq, 1);
    applyStimulus(0, 32'h18, 1, 0, 32'h0, 0, 0);
    checkOutput("t3_new_stall", pcStall, 0);
    applyStimulus(0, 32'h1C, 0, 1, 32'h0000_00B8, 0, 0);
    applyStimulus(0, 32'h1C, 0, 0, 32'h0, 1, 0);
    checkOutput("t3_new_pc", idPc, 32'h18);
    checkOutput("t3_new_instr", idInstr, 32'h0000_00B8);
    applyStimulus(0, 32'h1C, 0, 0, 32'h0, 0, 0);
    checkOutput("t3_new_popped", idValid, 0);

    // Simultaneous push and pop keeps one entry, order 0x8 then 0xC.
    applyStimulus(0, 32'h8, 1, 0, 32'h0, 0, 0);
    applyStimulus(0, 32'hC, 1, 0, 32'h0, 0, 0);
    applyStimulus(0, 32'h10, 0, 1, 32'h0000_00C8, 0, 0);
    checkOutput("t4_valid_early", idValid, 0);
    applyStimulus(0, 32'h10, 0, 1, 32'h0000_00CC, 1, 0);
    checkOutput("t4_first_pc", idPc, 32'h8);
    checkOutput("t4_first_instr", idInstr, 32'h0000_00C8);
    applyStimulus(0, 32'h10, 0, 0, 32'h0, 0, 0);
    checkOutput("t4_second_valid", idValid, 1);
    checkOutput("t4_second_pc", idPc, 32'hC);
    checkOutput("t4_second_instr", idInstr, 32'h0000_00CC);
    checkOutput("t4_count1_req", imemReq, 1);
    applyStimulus(0, 32'h10, 0, 0, 32'h0, 1, 0);
    applyStimulus(0, 32'h10, 0, 0, 32'h0, 0, 0);
    checkOutput("t4_empty", idValid, 0);

    // Misaligned PC handling depends on the build.
`ifdef IFETCH_ALIGN_CHECK_EN
    applyStimulus(0, 32'h6, 0, 0, 32'h0, 0, 0);
    checkOutput("t5_mis_req", imemReq, 0);
    checkOutput("t5_mis_stall", pcStall, 0);
    applyStimulus(0, 32'h20, 0, 0, 32'h0, 1, 0);
    checkOutput("t5_mis_valid", idValid, 1);
    checkOutput("t5_mis_pc", idPc, 32'h6);
    checkOutput("t5_mis_instr", idInstr, 32'h0);
    checkOutput("t5_mis_flag", idMisaligned, 1);
    applyStimulus(0, 32'h20, 0, 0, 32'h0, 0, 0);
    checkOutput("t5_mis_popped", idValid, 0);
`else
    applyStimulus(0, 32'h6, 0, 0, 32'h0, 0, 0);
    checkOutput("t5_addr", imemAddr, 32'h6);
    checkOutput("t5_req", imemReq, 1);
    applyStimulus(0, 32'h6, 1, 0, 32'h0, 0, 0);
    applyStimulus(0, 32'h20, 0, 1, 32'h0000_00D6, 1, 0);
    applyStimulus(0, 32'h20, 0, 0, 32'h0, 1, 0);
    checkOutput("t5_pc", idPc, 32'h6);
    checkOutput("t5_mis_tied", idMisaligned, 0);
    applyStimulus(0, 32'h20, 0, 0, 32'h0, 0, 0);
`endif

    // Reset with a request in flight: its late response is ignored.
    applyStimulus(0, 32'h30, 1, 0, 32'h0, 0, 0);
    checkOutput("t6_accept", pcStall, 0);
    applyStimulus(1, 32'h34, 0, 0, 32'h0, 0, 0);
    checkOutput("t6_rst_req", imemReq, 0);
    checkOutput("t6_rst_stall", pcStall, 1);
    applyStimulus(0, 32'h34, 0, 1, 32'h0000_DEAD, 1, 0);
    checkOutput("t6_valid_a", idValid, 0);
    applyStimulus(0, 32'h34, 0, 0, 32'h0, 1, 0);
    checkOutput("t6_valid_b", idValid, 0);
    checkOutput("t6_req", imemReq, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
